id_ex_pipeline_reg: RTL and testbench
=====================================

# id_ex_pipeline_reg

ID/EX pipeline register for the 5-stage RISC-V core. It sits directly downstream of the hazard detection unit and consumes its `stall_out`, `forward_a` and `forward_b` outputs. It registers decoded operands, control and forwarding selects into EX. On a load-use stall or branch flush it inserts a bubble, and it keeps saturating bubble/flush statistics counters.

## Interface
- `XLEN`, 32: datapath width.
- `CNT_W`, 16: width of the statistics counters.

Ports (clock and reset first):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `stall_in`  in  1  load-use stall from the hazard detection unit.
- `flush_in`  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- `valid_id`  in  1  ID holds a real instruction.
- `pc_id`, `rs1_data_id`, `rs2_data_id`, `imm_id`  in  XLEN  PC, register-file operands, immediate.
- `rs1_id`, `rs2_id`, `rd_id`  in  5  register indices.
- `reg_write_id`, `mem_read_id`, `mem_write_id`, `mem_to_reg_id`, `alu_src_id`, `branch_id`  in  1  control bits.
- `alu_op_id`  in  4  ALU operation.
- `forward_a_id`, `forward_b_id`  in  2  forwarding selects from the hazard unit.
- Every `*_id` input above has a matching `*_ex` output of the same width, registered.
- `valid_ex`  out  1  EX holds a real instruction.
- `pc_write`, `ifid_write`  out  1  combinational, `~stall_in | flush_in`; these gate the PC and IF/ID registers.
- `bubble_count`, `flush_count`  out  CNT_W  saturating event counters.

## Operation
- Per-edge priority is `rst` > `flush_in` > `stall_in` > normal.
- **Normal** (no rst, flush or stall): every `*_ex` register captures its `*_id` input, and `valid_ex <= valid_id`.
- **Bubble** (stall or flush):
  - `valid_ex`, `reg_write_ex`, `mem_read_ex`, `mem_write_ex`, `mem_to_reg_ex`, `branch_ex` and `alu_src_ex` are set to 0.
  - `alu_op_ex`, `rd_ex`, `rs1_ex`, `rs2_ex`, `forward_a_ex` and `forward_b_ex` are set to 0.
  - `pc_ex`, `rs1_data_ex`, `rs2_data_ex` and `imm_ex` hold their previous values.
- Forcing `rd_ex = 0` and `mem_read_ex = 0` removes the hazard unit's load-use condition on the next cycle. A single load-use therefore produces exactly one bubble.
- **Flush**: same register effect as a bubble. `pc_write`/`ifid_write` are forced to 1 so the fetch redirect is not blocked by a concurrent stall.
- **Counters**:
  - `bubble_count` increments on each edge with `stall_in=1`, `flush_in=0`, `rst=0`.
  - `flush_count` increments on each edge with `flush_in=1`, `rst=0`.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Simultaneous stall and flush counts as a flush only.

## Timing
- Latency is one cycle from ID inputs to EX outputs. The block has no combinational path from `*_id` to `*_ex`.
- `pc_write`/`ifid_write` are purely combinational from `stall_in`/`flush_in`, with zero latency.
- Reset values:
  - All `*_ex` outputs, `valid_ex` and both counters are 0.
  - `pc_write` and `ifid_write` follow their combinational equation during reset.
- Reset mid-stall: after the `rst` edge all state is 0. The first non-reset edge behaves as normal or bubble per the current inputs.
- Back-to-back stalls: each stalled edge inserts a bubble and increments `bubble_count`. The held data fields stay unchanged across all of them.
- X on `*_id` data inputs during a bubble must not propagate to outputs.

## Test plan
1. **Reset**: drive `rst=1` for 2 edges with nonzero inputs, then release.
   - Required: all `*_ex` outputs, `valid_ex` and both counters read 0.
2. **Normal pass-through**: `pc_id=0x100`, `rd_id=5`, `reg_write_id=1`, `forward_a_id=2'b10`, no stall.
   - Required: next edge gives `pc_ex=0x100`, `rd_ex=5`, `reg_write_ex=1`, `forward_a_ex=2'b10`, `valid_ex=1`.
3. **Load-use**: cycle N loads `lw x5` (`mem_read_id=1`, `rd_id=5`). At cycle N+1 raise `stall_in=1` while ID holds `add x6,x5,x1`.
   - Required after the N+1 edge: `valid_ex=0`, `rd_ex=0`, `mem_read_ex=0`, `pc_write=0` during N+1, `bubble_count=1`.
   - Next cycle, with stall low: `add` is captured with `rd_ex=6`.
4. **Flush with concurrent stall**: `stall_in=1`, `flush_in=1` for one edge.
   - Required: `pc_write=1`, `ifid_write=1`, bubble inserted, `flush_count=1`, `bubble_count` unchanged.
5. **Saturation**: with `CNT_W=4`, hold `stall_in=1` for 20 edges.
   - Required: `bubble_count` reaches 15 and stays 15. `pc_ex` and the other data fields are unchanged throughout.
6. **Reset during stall**: `stall_in=1` for 3 edges, then `rst=1` for one edge.
   - Required: counters return to 0. On the next edge with `stall_in=0`, `valid_id=1`, `valid_ex=1` and the ID values are captured.

Source files
------------

// File: rtl/id_ex_pipeline_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg_if
// Bundle carrying the decode-stage (ID) fields into the ID/EX pipeline
// register and the registered execute-stage (EX) fields back out, together
// with the hazard-control strobes.
//   master : the ID/hazard side. It drives the *_id fields, stall_in and
//            flush_in, and receives the *_ex fields, pc_write and ifid_write.
//   slave  : the pipeline register itself, with the opposite directions.
// Parameter XLEN sets the datapath width of the PC, operands and immediate.
// ---------------------------------------------------------------------------
interface id_ex_pipeline_reg_if #(
   parameter int XLEN = 32
);
   // hazard control
   logic            stall_in;
   logic            flush_in;
   logic            pc_write;
   logic            ifid_write;

   // decode-stage fields
   logic            valid_id;
   logic [XLEN-1:0] pc_id;
   logic [XLEN-1:0] rs1_data_id;
   logic [XLEN-1:0] rs2_data_id;
   logic [XLEN-1:0] imm_id;
   logic [4:0]      rs1_id;
   logic [4:0]      rs2_id;
   logic [4:0]      rd_id;
   logic            reg_write_id;
   logic            mem_read_id;
   logic            mem_write_id;
   logic            mem_to_reg_id;
   logic            alu_src_id;
   logic            branch_id;
   logic [3:0]      alu_op_id;
   logic [1:0]      forward_a_id;
   logic [1:0]      forward_b_id;

   // execute-stage fields (registered)
   logic            valid_ex;
   logic [XLEN-1:0] pc_ex;
   logic [XLEN-1:0] rs1_data_ex;
   logic [XLEN-1:0] rs2_data_ex;
   logic [XLEN-1:0] imm_ex;
   logic [4:0]      rs1_ex;
   logic [4:0]      rs2_ex;
   logic [4:0]      rd_ex;
   logic            reg_write_ex;
   logic            mem_read_ex;
   logic            mem_write_ex;
   logic            mem_to_reg_ex;
   logic            alu_src_ex;
   logic            branch_ex;
   logic [3:0]      alu_op_ex;
   logic [1:0]      forward_a_ex;
   logic [1:0]      forward_b_ex;

   modport master (
      output stall_in, flush_in,
      output valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
             rs1_id, rs2_id, rd_id, reg_write_id, mem_read_id, mem_write_id,
             mem_to_reg_id, alu_src_id, branch_id, alu_op_id,
             forward_a_id, forward_b_id,
      input  pc_write, ifid_write,
      input  valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
             rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex, mem_write_ex,
             mem_to_reg_ex, alu_src_ex, branch_ex, alu_op_ex,
             forward_a_ex, forward_b_ex
   );

   modport slave (
      input  stall_in, flush_in,
      input  valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
             rs1_id, rs2_id, rd_id, reg_write_id, mem_read_id, mem_write_id,
             mem_to_reg_id, alu_src_id, branch_id, alu_op_id,
             forward_a_id, forward_b_id,
      output pc_write, ifid_write,
      output valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
             rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex, mem_write_ex,
             mem_to_reg_ex, alu_src_ex, branch_ex, alu_op_ex,
             forward_a_ex, forward_b_ex
   );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
// ID/EX pipeline register of the 5-stage RISC-V core. It captures the decoded
// operands, the control bits and the forwarding selects for EX. On a load-use
// stall or a branch flush it inserts a bubble. It also keeps saturating
// bubble/flush event counters.
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   bus          : id_ex_pipeline_reg_if.slave. It carries the *_id inputs,
//                  the *_ex outputs, stall_in/flush_in and pc_write/ifid_write.
//   bubble_count : edges with stall_in=1 and flush_in=0, saturating
//   flush_count  : edges with flush_in=1, saturating
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   id_ex_pipeline_reg_if.slave bus,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            alu_src;
      logic            branch;
      logic [3:0]      alu_op;
      logic [1:0]      forward_a;
      logic [1:0]      forward_b;
   } stage_t;

   stage_t           id_w;
   stage_t           ex_q, ex_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             bubble_w;

   assign id_w = '{valid:      bus.valid_id,
                   pc:         bus.pc_id,
                   rs1_data:   bus.rs1_data_id,
                   rs2_data:   bus.rs2_data_id,
                   imm:        bus.imm_id,
                   rs1:        bus.rs1_id,
                   rs2:        bus.rs2_id,
                   rd:         bus.rd_id,
                   reg_write:  bus.reg_write_id,
                   mem_read:   bus.mem_read_id,
                   mem_write:  bus.mem_write_id,
                   mem_to_reg: bus.mem_to_reg_id,
                   alu_src:    bus.alu_src_id,
                   branch:     bus.branch_id,
                   alu_op:     bus.alu_op_id,
                   forward_a:  bus.forward_a_id,
                   forward_b:  bus.forward_b_id};

   // A flush has priority over a stall. Both leave the same bubble in EX.
   assign bubble_w = bus.flush_in | bus.stall_in;

   // A flush must let the fetch redirect through even when the hazard unit
   // is asking for a stall in the same cycle.
   assign bus.pc_write   = ~bus.stall_in | bus.flush_in;
   assign bus.ifid_write = ~bus.stall_in | bus.flush_in;

   always_comb begin
      ex_d         = id_w;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      if (bubble_w) begin
         // Clearing rd and mem_read drops the load-use condition on the next
         // cycle, so one load-use costs exactly one bubble. The data fields
         // hold their values, so X on the ID data inputs cannot reach EX.
         ex_d          = '0;
         ex_d.pc       = ex_q.pc;
         ex_d.rs1_data = ex_q.rs1_data;
         ex_d.rs2_data = ex_q.rs2_data;
         ex_d.imm      = ex_q.imm;
      end

      if (bus.flush_in) begin
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (bus.stall_in) begin
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bus.valid_ex      = ex_q.valid;
   assign bus.pc_ex         = ex_q.pc;
   assign bus.rs1_data_ex   = ex_q.rs1_data;
   assign bus.rs2_data_ex   = ex_q.rs2_data;
   assign bus.imm_ex        = ex_q.imm;
   assign bus.rs1_ex        = ex_q.rs1;
   assign bus.rs2_ex        = ex_q.rs2;
   assign bus.rd_ex         = ex_q.rd;
   assign bus.reg_write_ex  = ex_q.reg_write;
   assign bus.mem_read_ex   = ex_q.mem_read;
   assign bus.mem_write_ex  = ex_q.mem_write;
   assign bus.mem_to_reg_ex = ex_q.mem_to_reg;
   assign bus.alu_src_ex    = ex_q.alu_src;
   assign bus.branch_ex     = ex_q.branch;
   assign bus.alu_op_ex     = ex_q.alu_op;
   assign bus.forward_a_ex  = ex_q.forward_a;
   assign bus.forward_b_ex  = ex_q.forward_b;

   assign bubble_count = bubble_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1d;
      logic [XLEN-1:0] rs2d;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rw;
      logic            mr;
      logic            mw;
      logic            m2r;
      logic            as;
      logic            br;
      logic [3:0]      op;
      logic [1:0]      fa;
      logic [1:0]      fb;
   } ex_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] bubble_count;
   logic [CNT_W-1:0] flush_count;

   int   vectors     = 0;
   int   miscompares = 0;

   // reference model state
   ex_t  exp_ex;
   int   exp_bub;
   int   exp_fl;
   ex_t  cur_id;

   id_ex_pipeline_reg_if #(.XLEN(XLEN)) bus();

   id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .bubble_count (bubble_count),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   function automatic ex_t observe();
      ex_t o;
      o.valid = bus.valid_ex;     o.pc   = bus.pc_ex;
      o.rs1d  = bus.rs1_data_ex;  o.rs2d = bus.rs2_data_ex;
      o.imm   = bus.imm_ex;       o.rs1  = bus.rs1_ex;
      o.rs2   = bus.rs2_ex;       o.rd   = bus.rd_ex;
      o.rw    = bus.reg_write_ex; o.mr   = bus.mem_read_ex;
      o.mw    = bus.mem_write_ex; o.m2r  = bus.mem_to_reg_ex;
      o.as    = bus.alu_src_ex;   o.br   = bus.branch_ex;
      o.op    = bus.alu_op_ex;    o.fa   = bus.forward_a_ex;
      o.fb    = bus.forward_b_ex;
      return o;
   endfunction

   function automatic ex_t rand_id();
      ex_t v;
      v.valid = 1'($urandom);  v.pc   = $urandom;
      v.rs1d  = $urandom;      v.rs2d = $urandom;
      v.imm   = $urandom;      v.rs1  = 5'($urandom);
      v.rs2   = 5'($urandom);  v.rd   = 5'($urandom);
      v.rw    = 1'($urandom);  v.mr   = 1'($urandom);
      v.mw    = 1'($urandom);  v.m2r  = 1'($urandom);
      v.as    = 1'($urandom);  v.br   = 1'($urandom);
      v.op    = 4'($urandom);  v.fa   = 2'($urandom);
      v.fb    = 2'($urandom);
      return v;
   endfunction

   task automatic set_id(input ex_t v);
      cur_id            = v;
      bus.valid_id      = v.valid; bus.pc_id         = v.pc;
      bus.rs1_data_id   = v.rs1d;  bus.rs2_data_id   = v.rs2d;
      bus.imm_id        = v.imm;   bus.rs1_id        = v.rs1;
      bus.rs2_id        = v.rs2;   bus.rd_id         = v.rd;
      bus.reg_write_id  = v.rw;    bus.mem_read_id   = v.mr;
      bus.mem_write_id  = v.mw;    bus.mem_to_reg_id = v.m2r;
      bus.alu_src_id    = v.as;    bus.branch_id     = v.br;
      bus.alu_op_id     = v.op;    bus.forward_a_id  = v.fa;
      bus.forward_b_id  = v.fb;
   endtask

   // Behavioural model of one rising edge: reset clears everything, a stall
   // or flush leaves an empty slot that keeps only the data words, otherwise
   // EX takes a copy of ID. Counters count events and clamp at CMAX.
   task automatic step();
      ex_t held;
      @(posedge clk);
      if (rst) begin
         exp_ex  = '0;
         exp_bub = 0;
         exp_fl  = 0;
      end else begin
         if (bus.flush_in)      exp_fl  = (exp_fl  < CMAX) ? exp_fl  + 1 : CMAX;
         else if (bus.stall_in) exp_bub = (exp_bub < CMAX) ? exp_bub + 1 : CMAX;
         if (bus.flush_in || bus.stall_in) begin
            held        = exp_ex;
            exp_ex      = '0;
            exp_ex.pc   = held.pc;
            exp_ex.rs1d = held.rs1d;
            exp_ex.rs2d = held.rs2d;
            exp_ex.imm  = held.imm;
         end else begin
            exp_ex = cur_id;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      ex_t v;
      v = rand_id();
      v.valid = 1'b1; v.rw = 1'b1; v.rd = 5'd9; v.pc = 32'h0000_0ABC;
      set_id(v);
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (observe() !== ex_t'(0)) begin
         miscompares++;
         $display("FAIL reset_ex: got %h, want 0", observe());
      end
      vectors++;
      if (bubble_count !== 4'd0 || flush_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_cnt: got bub=%0d fl=%0d, want 0/0", bubble_count, flush_count);
      end
      vectors++;
      if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pcw: got %b/%b, want 1/1", bus.pc_write, bus.ifid_write);
      end
      rst = 1'b0;
      $display("reset: done, ex cleared and counters zero expected");
   endtask

   task automatic test_passthrough();
      ex_t v;
      v = '0;
      v.valid = 1'b1; v.pc = 32'h100; v.rd = 5'd5; v.rw = 1'b1; v.fa = 2'b10;
      set_id(v);
      step();
      vectors++;
      if (bus.pc_ex !== 32'h100) begin
         miscompares++; $display("FAIL pass_pc: got %h, want 100", bus.pc_ex);
      end
      vectors++;
      if (bus.rd_ex !== 5'd5) begin
         miscompares++; $display("FAIL pass_rd: got %0d, want 5", bus.rd_ex);
      end
      vectors++;
      if (bus.reg_write_ex !== 1'b1 || bus.valid_ex !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_ctl: got rw=%b v=%b, want 1/1", bus.reg_write_ex, bus.valid_ex);
      end
      vectors++;
      if (bus.forward_a_ex !== 2'b10) begin
         miscompares++; $display("FAIL pass_fa: got %b, want 10", bus.forward_a_ex);
      end
      $display("passthrough: pc=0x100 rd=5 applied");
   endtask

   task automatic test_load_use();
      ex_t v;
      // cycle N: lw x5
      v = '0;
      v.valid = 1'b1; v.pc = 32'h104; v.rd = 5'd5; v.rw = 1'b1; v.mr = 1'b1;
      v.m2r = 1'b1; v.as = 1'b1; v.imm = 32'h10; v.rs1d = 32'h2000;
      set_id(v);
      step();
      vectors++;
      if (bus.mem_read_ex !== 1'b1 || bus.rd_ex !== 5'd5) begin
         miscompares++;
         $display("FAIL lu_load: got mr=%b rd=%0d, want 1/5", bus.mem_read_ex, bus.rd_ex);
      end
      // cycle N+1: add x6,x5,x1 with stall
      v = '0;
      v.valid = 1'b1; v.pc = 32'h108; v.rd = 5'd6; v.rs1 = 5'd5; v.rs2 = 5'd1;
      v.rw = 1'b1; v.rs1d = 32'h55; v.rs2d = 32'h11;
      set_id(v);
      bus.stall_in = 1'b1;
      #1;
      vectors++;
      if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0) begin
         miscompares++;
         $display("FAIL lu_pcw: got %b/%b, want 0/0", bus.pc_write, bus.ifid_write);
      end
      step();
      vectors++;
      if (bus.valid_ex !== 1'b0 || bus.rd_ex !== 5'd0 || bus.mem_read_ex !== 1'b0) begin
         miscompares++;
         $display("FAIL lu_bubble: got v=%b rd=%0d mr=%b, want 0/0/0",
                  bus.valid_ex, bus.rd_ex, bus.mem_read_ex);
      end
      vectors++;
      if (bus.pc_ex !== 32'h104 || bus.imm_ex !== 32'h10) begin
         miscompares++;
         $display("FAIL lu_hold: got pc=%h imm=%h, want 104/10", bus.pc_ex, bus.imm_ex);
      end
      vectors++;
      if (bubble_count !== 4'd1) begin
         miscompares++; $display("FAIL lu_bcnt: got %0d, want 1", bubble_count);
      end
      bus.stall_in = 1'b0;
      step();
      vectors++;
      if (bus.rd_ex !== 5'd6 || bus.valid_ex !== 1'b1 || bus.rs1_ex !== 5'd5 || bus.pc_ex !== 32'h108) begin
         miscompares++;
         $display("FAIL lu_add: got rd=%0d v=%b rs1=%0d pc=%h, want 6/1/5/108",
                  bus.rd_ex, bus.valid_ex, bus.rs1_ex, bus.pc_ex);
      end
      $display("load_use: lw x5 then add x6 with one stall applied");
   endtask

   task automatic test_flush_stall();
      ex_t v;
      v = rand_id();
      v.valid = 1'b1; v.rw = 1'b1; v.rd = 5'd7;
      set_id(v);
      bus.stall_in = 1'b1;
      bus.flush_in = 1'b1;
      #1;
      vectors++;
      if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
         miscompares++;
         $display("FAIL fs_pcw: got %b/%b, want 1/1", bus.pc_write, bus.ifid_write);
      end
      step();
      vectors++;
      if (bus.valid_ex !== 1'b0 || bus.reg_write_ex !== 1'b0 || bus.rd_ex !== 5'd0) begin
         miscompares++;
         $display("FAIL fs_bubble: got v=%b rw=%b rd=%0d, want 0/0/0",
                  bus.valid_ex, bus.reg_write_ex, bus.rd_ex);
      end
      vectors++;
      if (flush_count !== 4'd1 || bubble_count !== 4'd1) begin
         miscompares++;
         $display("FAIL fs_cnt: got fl=%0d bub=%0d, want 1/1", flush_count, bubble_count);
      end
      vectors++;
      if (bus.pc_ex !== 32'h108) begin
         miscompares++; $display("FAIL fs_hold: got pc=%h, want 108", bus.pc_ex);
      end
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
      $display("flush_stall: concurrent stall+flush applied");
   endtask

   task automatic test_saturation();
      ex_t v;
      int  want;
      v = rand_id();
      v.pc = 32'hDEAD_BEE0; v.rs1d = 32'h1111_2222; v.rs2d = 32'h3333_4444;
      v.imm = 32'h5555_6666;
      set_id(v);
      step();
      // data inputs go unknown while stalled; none of it may reach EX
      bus.pc_id       = 'x;
      bus.rs1_data_id = 'x;
      bus.rs2_data_id = 'x;
      bus.imm_id      = 'x;
      bus.stall_in    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         want = (i + 2 > CMAX) ? CMAX : i + 2;
         vectors++;
         if (int'(bubble_count) !== want) begin
            miscompares++;
            $display("FAIL sat_cnt edge %0d: got %0d, want %0d", i, bubble_count, want);
         end
         vectors++;
         if (bus.pc_ex !== 32'hDEAD_BEE0 || bus.rs1_data_ex !== 32'h1111_2222 ||
             bus.rs2_data_ex !== 32'h3333_4444 || bus.imm_ex !== 32'h5555_6666) begin
            miscompares++;
            $display("FAIL sat_hold edge %0d: got pc=%h r1=%h r2=%h imm=%h", i,
                     bus.pc_ex, bus.rs1_data_ex, bus.rs2_data_ex, bus.imm_ex);
         end
      end
      bus.stall_in = 1'b0;
      set_id(v);
      $display("saturation: 20 stalled edges applied, bubble_count at %0d", bubble_count);
   endtask

   task automatic test_reset_during_stall();
      ex_t v;
      bus.stall_in = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if (bubble_count !== 4'd0 || flush_count !== 4'd0) begin
         miscompares++;
         $display("FAIL rds_cnt: got bub=%0d fl=%0d, want 0/0", bubble_count, flush_count);
      end
      vectors++;
      if (observe() !== ex_t'(0)) begin
         miscompares++; $display("FAIL rds_ex: got %h, want 0", observe());
      end
      bus.stall_in = 1'b0;
      v = rand_id();
      v.valid = 1'b1;
      set_id(v);
      step();
      vectors++;
      if (bus.valid_ex !== 1'b1 || bus.pc_ex !== v.pc || bus.rd_ex !== v.rd || bus.imm_ex !== v.imm) begin
         miscompares++;
         $display("FAIL rds_capture: got v=%b pc=%h rd=%0d imm=%h, want 1/%h/%0d/%h",
                  bus.valid_ex, bus.pc_ex, bus.rd_ex, bus.imm_ex, v.pc, v.rd, v.imm);
      end
      $display("reset_during_stall: 3 stalls, reset, capture applied");
   endtask

   task automatic test_random();
      ex_t obs;
      for (int i = 0; i < 300; i++) begin
         set_id(rand_id());
         bus.stall_in = ($urandom_range(0, 3) == 0);
         bus.flush_in = ($urandom_range(0, 9) == 0);
         rst          = ($urandom_range(0, 39) == 0);
         #1;
         vectors++;
         if (bus.pc_write !== (~bus.stall_in | bus.flush_in)) begin
            miscompares++;
            $display("FAIL rnd_pcw cyc %0d: got %b with stall=%b flush=%b",
                     i, bus.pc_write, bus.stall_in, bus.flush_in);
         end
         step();
         obs = observe();
         vectors++;
         if (obs !== exp_ex) begin
            miscompares++;
            $display("FAIL rnd_ex cyc %0d: got %h, want %h", i, obs, exp_ex);
         end
         vectors++;
         if (int'(bubble_count) !== exp_bub || int'(flush_count) !== exp_fl) begin
            miscompares++;
            $display("FAIL rnd_cnt cyc %0d: got bub=%0d fl=%0d, want %0d/%0d",
                     i, bubble_count, flush_count, exp_bub, exp_fl);
         end
         $display("rnd %0d: rst=%b stall=%b flush=%b valid_ex=%b bub=%0d fl=%0d",
                  i, rst, bus.stall_in, bus.flush_in, obs.valid, bubble_count, flush_count);
      end
      rst          = 1'b0;
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
   endtask

   initial begin
      exp_ex       = '0;
      exp_bub      = 0;
      exp_fl       = 0;
      rst          = 1'b1;
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
      set_id('0);
      test_reset();
      test_passthrough();
      test_load_use();
      test_flush_stall();
      test_saturation();
      test_reset_during_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
